ram_fifo: RTL and testbench
===========================

// Module: ram_fifo
// PURPOSE
//  Synchronous first-word-fall-through FIFO built on the team's dual port block RAM pattern.
//  Adds a valid/ready handshake, occupancy tracking, programmable almost flags and a synchronous flush.
//  Buffers byte/word streams between the F8 core and peripherals (UART, SPI, DMA) in one clock domain.
//  The storage array maps to iCE40 4kb EBR or GateMate block RAM: one write port, one registered read port.
// PARAMETERS
//  ADDRBITS      9                   log2 of capacity; DEPTH = 1 << ADDRBITS entries
//  DATAWIDTH     8                   word width in bits
//  ALMOST_FULL   (1 << ADDRBITS) - 4 almost_full asserted when level >= ALMOST_FULL
//  ALMOST_EMPTY  4                   almost_empty asserted when level <= ALMOST_EMPTY
// PORTS
//  clk           in   1           single clock, rising edge
//  reset         in   1           asynchronous, active-high; clears all state
//  flush         in   1           synchronous clear of contents
//  in_data       in   DATAWIDTH   write word
//  in_valid      in   1           producer offers in_data
//  in_ready      out  1           FIFO accepts; push occurs on an edge where in_valid & in_ready
//  out_data      out  DATAWIDTH   head word; valid only while out_valid
//  out_valid     out  1           head word present
//  out_ready     in   1           consumer takes; pop occurs on an edge where out_valid & out_ready
//  level         out  ADDRBITS+1  words accepted and not yet popped, 0..DEPTH
//  almost_full   out  1           level >= ALMOST_FULL
//  almost_empty  out  1           level <= ALMOST_EMPTY
// BEHAVIOUR
//  - Reset is asynchronous and active-high. While reset is high, all outputs are registered zeros,
//    except almost_empty = 1. in_ready rises on the first clk edge after reset deasserts.
//  - Storage: mem[DEPTH]. Write address is wr_ptr and read address is rd_ptr, each ADDRBITS wide;
//    both wrap modulo DEPTH.
//  - The RAM read is registered. A read-during-write to the same address forwards din.
//  - level counts words in RAM, in the read pipeline and in the output register.
//    Therefore at most DEPTH words are ever held, and no unread slot is overwritten.
//  - in_ready = (level != DEPTH) & ~flush. It is registered and updates on the edge that changes level.
//  - Push: mem[wr_ptr] <= in_data, wr_ptr++, level++.
//  - Pop: out_valid drops or advances to the next word; level--.
//  - Push and pop on the same edge leave level unchanged. This is legal at any level, including DEPTH-1.
//    At level == DEPTH, in_ready = 0, so only the pop happens; in_ready is 1 after that edge.
//  - Latency: a word pushed on edge E0 into an empty FIFO gives out_valid = 1 after edge E2.
//    It is never earlier, even with bypass.
//  - Throughput: with in_valid and out_ready held high, one word per cycle in steady state, no bubbles.
//  - Prefetch FSM for the output stage:
//      EMPTY : output register empty. If RAM holds data, issue a read -> FETCH.
//      FETCH : RAM dout loads the output register -> VALID.
//              If another word is unread and a pop is expected, keep one read in flight.
//      VALID : out_valid = 1, out_data stable until popped.
//              On pop, present the prefetched word if one is in flight, else go to EMPTY or FETCH.
//    out_data holds its value while out_valid & ~out_ready. No word is ever skipped or duplicated.
//  - Ordering: strict FIFO. Wrap-around of wr_ptr and rd_ptr past DEPTH-1 is seamless.
//  - almost_full and almost_empty are registered and change on the same edge as level.
//  - flush high on an edge: pointers = 0, level = 0, out_valid = 0 and any in-flight read is discarded.
//    Any push or pop offered that cycle is ignored. flush has priority over push and pop.
//  - Reset or flush mid-stream: the RAM contents are not cleared, but they are never presented.
// TESTING
//  1. Reset: assert reset mid-stream -> out_valid = 0, level = 0, almost_empty = 1, in_ready = 0 immediately.
//     in_ready = 1 one edge after release.
//  2. Latency: push 0xA5 into an empty FIFO at edge E0 -> out_valid = 1 and out_data = 0xA5 after E2.
//     level = 1 after E0.
//  3. Fill: ADDRBITS = 4, push 16 words 0x00..0x0F -> level = 16, in_ready = 0, almost_full = 1.
//     A 17th in_valid is not accepted. Pop all -> 0x00..0x0F in order, level = 0.
//  4. Streaming: in_valid = out_ready = 1 for 100 cycles with an incrementing pattern -> 1 word/cycle.
//     Output sequence matches input, and pointers wrap past DEPTH-1.
//  5. Backpressure/simultaneous: at level = 16 (full), pop and in_valid together -> only the pop occurs.
//     in_ready = 1 next cycle. At level = 15, push and pop together -> level stays 15.
//  6. Flush: with 5 words queued and out_valid = 1, flush plus push 0x77 -> level = 0 and out_valid = 0 next edge.
//     0x77 is never output. A push after flush emerges normally.

Source files
------------

// File: rtl/ram_fifo.sv
// First-word-fall-through FIFO on a single-write, registered-read block RAM.
// A two-entry output pipeline (RAM read register + output register) sustains one word per cycle.
module ram_fifo #(
    parameter int unsigned ADDRBITS     = 9,
    parameter int unsigned DATAWIDTH    = 8,
    parameter int unsigned ALMOST_FULL  = (1 << ADDRBITS) - 4,
    parameter int unsigned ALMOST_EMPTY = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDRBITS:0]    level,
    output logic                 almost_full,
    output logic                 almost_empty
);

    localparam int unsigned DEPTH = 1 << ADDRBITS;
    localparam logic [ADDRBITS:0] LevelFull = (ADDRBITS + 1)'(DEPTH);
    localparam logic [ADDRBITS:0] LevelAf   = (ADDRBITS + 1)'(ALMOST_FULL);
    localparam logic [ADDRBITS:0] LevelAe   = (ADDRBITS + 1)'(ALMOST_EMPTY);

    typedef enum logic [1:0] {StEmpty, StFetch, StValid} state_e;

    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [DATAWIDTH-1:0] dout_q;

    state_e               state_q, state_d;
    logic                 pf_q, pf_d;
    logic [ADDRBITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDRBITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDRBITS:0]    level_q, level_d;
    logic [DATAWIDTH-1:0] out_data_q, out_data_d;
    logic                 in_ready_q, in_ready_d;
    logic                 almost_full_q, almost_full_d;
    logic                 almost_empty_q, almost_empty_d;

    logic                 push, pop, rd_en, load_out, ram_avail;
    logic [ADDRBITS:0]    held;

    always_comb begin
        push = in_valid & in_ready_q & ~flush;
        pop  = (state_q == StValid) & out_ready & ~flush;

        // Words already out of the RAM: one in the read register and/or one in the output register.
        unique case (state_q)
            StFetch: held = (ADDRBITS + 1)'(1);
            StValid: held = pf_q ? (ADDRBITS + 1)'(2) : (ADDRBITS + 1)'(1);
            default: held = '0;
        endcase
        ram_avail = level_q > held;

        state_d  = state_q;
        pf_d     = pf_q;
        rd_en    = 1'b0;
        load_out = 1'b0;

        unique case (state_q)
            StEmpty: begin
                pf_d = 1'b0;
                if (ram_avail) begin
                    rd_en   = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                load_out = 1'b1;
                state_d  = StValid;
                rd_en    = ram_avail;
                pf_d     = ram_avail;
            end
            StValid: begin
                if (pop) begin
                    if (pf_q) begin
                        load_out = 1'b1;
                        rd_en    = ram_avail;
                        pf_d     = ram_avail;
                    end else if (ram_avail) begin
                        rd_en   = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StEmpty;
                    end
                end else if (!pf_q && ram_avail) begin
                    rd_en = 1'b1;
                    pf_d  = 1'b1;
                end
            end
            default: begin
                state_d = StEmpty;
                pf_d    = 1'b0;
            end
        endcase

        wr_ptr_d = wr_ptr_q + ADDRBITS'(push);
        rd_ptr_d = rd_ptr_q + ADDRBITS'(rd_en);

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end

        if (flush) begin
            state_d  = StEmpty;
            pf_d     = 1'b0;
            rd_en    = 1'b0;
            load_out = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end

        out_data_d     = load_out ? dout_q : out_data_q;
        in_ready_d     = level_d != LevelFull;
        almost_full_d  = level_d >= LevelAf;
        almost_empty_d = level_d <= LevelAe;
    end

    // Storage and read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
        if (rd_en) begin
            dout_q <= (push && (wr_ptr_q == rd_ptr_q)) ? in_data : mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StEmpty;
            pf_q           <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            out_data_q     <= '0;
            in_ready_q     <= 1'b0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            pf_q           <= pf_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            out_data_q     <= out_data_d;
            in_ready_q     <= in_ready_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_data     = out_data_q;
    assign out_valid    = (state_q == StValid);
    assign level        = level_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;

endmodule

// File: tb/tb_ram_fifo.sv
// Directed bench for ram_fifo at 16 entries: reset, latency, fill/backpressure,
// streaming with a reference queue, flush and mid-stream reset.
module tb_ram_fifo;

    localparam int unsigned AB = 4;
    localparam int unsigned DW = 8;

    logic          clk;
    logic          reset;
    logic          flush;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AB:0]   level;
    logic          almost_full;
    logic          almost_empty;

    int n_vec = 0;
    int n_err = 0;

    ram_fifo #(
        .ADDRBITS    (AB),
        .DATAWIDTH   (DW),
        .ALMOST_FULL (12),
        .ALMOST_EMPTY(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .almost_full (almost_full),
        .almost_empty(almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a head word, checks it, and pops it on the next edge.
    task automatic pop_expect(input string tag, input logic [DW-1:0] exp);
        int waited = 0;
        out_ready = 1'b1;
        while (!out_valid && waited < 20) begin
            step();
            waited++;
        end
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        if (out_valid) begin
            check(tag, 32'(out_data), 32'(exp));
            step();
        end
    endtask

    initial begin
        logic [DW-1:0] q[$];
        logic [DW-1:0] e;
        int            pops;

        reset     = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 reset = 1'b1;
        #2;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst level", 32'(level), 32'd0);
        check("rst almost_empty", 32'(almost_empty), 32'd1);
        check("rst in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rel in_ready before edge", 32'(in_ready), 32'd0);
        step();
        check("rel in_ready", 32'(in_ready), 32'd1);

        // Latency
        in_data  = 8'hA5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("lat level E0", 32'(level), 32'd1);
        check("lat valid E0", 32'(out_valid), 32'd0);
        step();
        check("lat valid E1", 32'(out_valid), 32'd0);
        step();
        check("lat valid E2", 32'(out_valid), 32'd1);
        check("lat data E2", 32'(out_data), 32'hA5);
        pop_expect("lat pop", 8'hA5);
        out_ready = 1'b0;
        check("lat level end", 32'(level), 32'd0);

        // Fill
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'(i);
            step();
            check("fill level", 32'(level), 32'(i + 1));
            if (i == 3)  check("fill ae at 4", 32'(almost_empty), 32'd1);
            if (i == 4)  check("fill ae at 5", 32'(almost_empty), 32'd0);
            if (i == 10) check("fill af at 11", 32'(almost_full), 32'd0);
            if (i == 11) check("fill af at 12", 32'(almost_full), 32'd1);
        end
        check("full in_ready", 32'(in_ready), 32'd0);
        check("full almost_full", 32'(almost_full), 32'd1);
        check("full head valid", 32'(out_valid), 32'd1);
        check("full head data", 32'(out_data), 32'h00);
        in_data = 8'h55;
        step();
        check("17th rejected", 32'(level), 32'd16);

        // Full: pop with in_valid -> only pop
        out_ready = 1'b1;
        step();
        check("full pop level", 32'(level), 32'd15);
        check("full pop in_ready", 32'(in_ready), 32'd1);
        check("after pop head", 32'(out_data), 32'h01);
        in_data = 8'h10;
        step();
        in_valid = 1'b0;
        check("push+pop at 15", 32'(level), 32'd15);
        for (int i = 2; i <= 16; i++) pop_expect("drain", 8'(i));
        out_ready = 1'b0;
        check("drain level", 32'(level), 32'd0);

        // Streaming with wrap
        pops      = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = 8'(8'h20 + i);
            check("stream in_ready", 32'(in_ready), 32'd1);
            if (in_ready) q.push_back(in_data);
            if (out_valid) begin
                pops++;
                if (q.size() == 0) begin
                    check("stream underflow", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("stream data", 32'(out_data), 32'(e));
                end
            end
            step();
        end
        in_valid = 1'b0;
        check("stream pops", 32'(pops), 32'd97);
        check("stream level", 32'(level), 32'd3);
        while (q.size() > 0) begin
            e = q.pop_front();
            pop_expect("stream drain", e);
        end
        out_ready = 1'b0;
        check("stream level end", 32'(level), 32'd0);

        // Flush
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(8'h60 + i);
            step();
        end
        check("pre-flush valid", 32'(out_valid), 32'd1);
        check("pre-flush level", 32'(level), 32'd5);
        check("pre-flush head", 32'(out_data), 32'h60);
        flush   = 1'b1;
        in_data = 8'h77;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush level", 32'(level), 32'd0);
        check("flush valid", 32'(out_valid), 32'd0);
        check("flush almost_empty", 32'(almost_empty), 32'd1);
        check("flush in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("flush stays empty", 32'(out_valid), 32'd0);
        end
        in_data  = 8'h88;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("post-flush level", 32'(level), 32'd1);
        pop_expect("post-flush pop", 8'h88);
        out_ready = 1'b0;
        check("post-flush level end", 32'(level), 32'd0);

        // Mid-stream reset
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'h90 + i);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        #2 reset = 1'b1;
        #1;
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst level", 32'(level), 32'd0);
        check("mid rst almost_empty", 32'(almost_empty), 32'd1);
        check("mid rst in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        check("mid rel in_ready before edge", 32'(in_ready), 32'd0);
        step();
        check("mid rel in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid rel stays empty", 32'(out_valid), 32'd0);
        end
        check("mid rel level", 32'(level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
